// File: rtl/branch_predictor_if.sv
// Fetch lookup and execute feedback bundle for branch_predictor.
// master = fetch/execute side, slave = predictor.
`ifndef PC_SIZE
`define PC_SIZE 16
`endif

interface branch_predictor_if #(
  parameter int PC_W = `PC_SIZE
);
  logic            fetch_pc_valid_unused;
  logic [PC_W-1:0] fetch_pc;
  logic            predict_taken;
  logic [PC_W-1:0] predict_target;
  logic            fb_branch;
  logic [PC_W-1:0] fb_pc;
  logic [PC_W-1:0] fb_predict_target;
  logic            fb_predict_taken;
  logic [PC_W-1:0] fb_feedback_target;
  logic            fb_feedback_taken;
  logic            redirect;
  logic [PC_W-1:0] redirect_pc;

  modport master (
    output fetch_pc, fb_branch, fb_pc,
    output fb_predict_target, fb_predict_taken,
    output fb_feedback_target, fb_feedback_taken,
    input  predict_taken, predict_target,
    input  redirect, redirect_pc
  );

  modport slave (
    input  fetch_pc, fb_branch, fb_pc,
    input  fb_predict_target, fb_predict_taken,
    input  fb_feedback_target, fb_feedback_taken,
    output predict_taken, predict_target,
    output redirect, redirect_pc
  );
endinterface

// File: rtl/branch_predictor.sv
// Direct-mapped BTB with 2-bit counters; flags mispredicts from execute.
// Optional BP_STATS_EN adds saturating branch/mispredict counters.
`ifndef PC_SIZE
`define PC_SIZE 16
`endif

module branch_predictor #(
  parameter int PC_W    = `PC_SIZE,
  parameter int ENTRIES = 16
) (
  input  logic clk,
  input  logic rst,
  branch_predictor_if.slave bp
`ifdef BP_STATS_EN
  ,
  output logic [31:0] stat_branches,
  output logic [31:0] stat_mispredicts
`endif
);
  localparam int IDX_W = $clog2(ENTRIES);
  localparam int TAG_W = PC_W - IDX_W;

  logic [ENTRIES-1:0] valid;
  logic [1:0]         ctr    [ENTRIES];
  logic [TAG_W-1:0]   tag    [ENTRIES];
  logic [PC_W-1:0]    target [ENTRIES];

  logic [IDX_W-1:0] fi;
  logic [IDX_W-1:0] ui;
  logic [TAG_W-1:0] ftag;
  logic [TAG_W-1:0] utag;
  logic             hit;
  logic             fb_hit;
  logic             tk;
  logic             mis;

  assign fi   = bp.fetch_pc[IDX_W-1:0];
  assign ftag = bp.fetch_pc[PC_W-1:IDX_W];
  assign ui   = bp.fb_pc[IDX_W-1:0];
  assign utag = bp.fb_pc[PC_W-1:IDX_W];
  assign tk   = bp.fb_feedback_taken;

  assign hit    = valid[fi] && (tag[fi] == ftag);
  assign fb_hit = valid[ui] && (tag[ui] == utag);

  assign bp.predict_taken  = hit && ctr[fi][1];
  assign bp.predict_target = bp.predict_taken
                           ? target[fi]
                           : bp.fetch_pc + 1'b1;

  assign mis =
    (bp.fb_predict_taken != tk) ||
    (tk && (bp.fb_predict_target != bp.fb_feedback_target));

  assign bp.redirect    = !rst && bp.fb_branch && mis;
  assign bp.redirect_pc = (rst || !bp.fb_branch) ? '0
                        : tk ? bp.fb_feedback_target
                        : bp.fb_pc + 1'b1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid <= '0;
      for (int i = 0; i < ENTRIES; i++) ctr[i] <= 2'b01;
    end else if (bp.fb_branch) begin
      if (fb_hit) begin
        if (tk && ctr[ui] != 2'b11)
          ctr[ui] <= ctr[ui] + 2'd1;
        else if (!tk && ctr[ui] != 2'b00)
          ctr[ui] <= ctr[ui] - 2'd1;
      end else if (tk) begin
        valid[ui] <= 1'b1;
        ctr[ui]   <= 2'b10;
      end
    end
  end

  // Tag/target carry no reset; valid gates their use.
  always_ff @(posedge clk) begin
    if (!rst && bp.fb_branch && tk) begin
      tag[ui]    <= utag;
      target[ui] <= bp.fb_feedback_target;
    end
  end

`ifdef BP_STATS_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stat_branches    <= '0;
      stat_mispredicts <= '0;
    end else begin
      if (bp.fb_branch && stat_branches != 32'hFFFF_FFFF)
        stat_branches <= stat_branches + 32'd1;
      if (bp.redirect && stat_mispredicts != 32'hFFFF_FFFF)
        stat_mispredicts <= stat_mispredicts + 32'd1;
    end
  end
`endif
endmodule
